// File: rtl/auth_msg_tx_pkg.sv
// -----------------------------------------------------------------------------
// auth_msg_tx_pkg
// Shared definitions for the authentication message transmitter: header and
// byte geometry, protocol constants, command codes, FSM state encoding and
// the CRC-8 byte update used by the optional trailer.
// Build option: AUTH_TX_CRC_EN adds the CRC trailer state.
// -----------------------------------------------------------------------------
package auth_msg_tx_pkg;

    localparam int SIZE_OF_HEADER_VARS     = 8;
    localparam int SIZE_OF_HEADER_IN_BYTES = 4;
    localparam int BYTE_W                  = SIZE_OF_HEADER_VARS;
    localparam int HDR_BYTES               = SIZE_OF_HEADER_IN_BYTES;
    localparam int HDR_W                   = HDR_BYTES * BYTE_W;
    localparam int MAX_PL                  = 255;

    localparam logic [7:0] PROTOCOL_VERSION = 8'h01;
    localparam logic [7:0] CRC8_POLY        = 8'h07;

    typedef enum logic [7:0] {
        CMD_DIGESTS        = 8'h81,
        CMD_CERTIFICATE    = 8'h82,
        CMD_CHALLENGE_AUTH = 8'h83,
        CMD_ERROR          = 8'hFF
    } auth_cmd_e;

`ifdef AUTH_TX_CRC_EN
    typedef enum logic [2:0] {
        ST_IDLE, ST_HDR, ST_PL, ST_CRC, ST_DONE
    } state_e;
    localparam bit     CRC_EN     = 1'b1;
    localparam state_e ST_TRAILER = ST_CRC;
`else
    typedef enum logic [2:0] {
        ST_IDLE, ST_HDR, ST_PL, ST_DONE
    } state_e;
    localparam bit     CRC_EN     = 1'b0;
    localparam state_e ST_TRAILER = ST_DONE;
`endif

    // Payload length clamp; the counter never has to hold more than MAX_PL.
    function automatic logic [7:0] sat_len(input logic [7:0] len);
        return (int'(len) > MAX_PL) ? 8'(MAX_PL) : len;
    endfunction

    // CRC-8, MSB first, whole byte folded in before the eight shifts.
    function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] din);
        logic [7:0] c;
        c = crc ^ din;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/auth_msg_tx_if.sv
// -----------------------------------------------------------------------------
// auth_msg_tx_if
// Byte links of the transmitter: payload source (pl_*) into the block and
// the transport link (tx_*) out of it.
//   master : the transmitter (drives tx_data/tx_valid/tx_last, pl_ready)
//   slave  : the environment (drives tx_ready, pl_data/pl_valid)
// -----------------------------------------------------------------------------
interface auth_msg_tx_if;
    import auth_msg_tx_pkg::*;

    logic [BYTE_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_last;
    logic              tx_ready;
    logic [BYTE_W-1:0] pl_data;
    logic              pl_valid;
    logic              pl_ready;

    modport master (
        output tx_data, tx_valid, tx_last, pl_ready,
        input  tx_ready, pl_data, pl_valid
    );

    modport slave (
        input  tx_data, tx_valid, tx_last, pl_ready,
        output tx_ready, pl_data, pl_valid
    );

endinterface

// File: rtl/auth_crc8.sv
// -----------------------------------------------------------------------------
// auth_crc8
// Byte-serial CRC-8 (poly 0x07, init 0x00) accumulator. Present only when
// AUTH_TX_CRC_EN is defined.
//   clk, reset : clock, synchronous active-high reset
//   clr        : restart the CRC at 0x00 (start of a message)
//   en         : fold din into the CRC (one accepted byte)
//   din        : byte being sent
//   crc        : running CRC over all bytes folded in since clr
// -----------------------------------------------------------------------------
`ifdef AUTH_TX_CRC_EN
module auth_crc8
    import auth_msg_tx_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       en,
    input  logic [7:0] din,
    output logic [7:0] crc
);

    logic [7:0] crc_q;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            crc_q <= 8'h00;
        end else if (en) begin
            crc_q <= crc8_update(crc_q, din);
        end
    end

    assign crc = crc_q;

endmodule
`endif

// File: rtl/auth_msg_tx.sv
// -----------------------------------------------------------------------------
// auth_msg_tx
// Captures a 4-byte header and optional payload on the rising edge of
// MSG_ready and serialises them, header MSB byte first, onto a valid/ready
// byte link. One message in flight; requests while busy are dropped and
// flagged with overrun_err.
// Build option: AUTH_TX_CRC_EN appends a CRC-8 byte (carries tx_last).
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   MSG_ready    : request level, a rising edge starts a message
//   header       : {version, cmd, param1, param2}, byte 0 in the MSBs
//   pl_len       : payload byte count, sampled with header
//   link         : pl_* payload source and tx_* transport link (master side)
//   busy         : message in flight
//   msg_done     : one-cycle pulse after the last byte handshake
//   overrun_err  : one-cycle pulse when a request arrives while busy
// -----------------------------------------------------------------------------
module auth_msg_tx
    import auth_msg_tx_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             MSG_ready,
    input  logic [HDR_W-1:0] header,
    input  logic [7:0]       pl_len,
    auth_msg_tx_if.master    link,
    output logic             busy,
    output logic             msg_done,
    output logic             overrun_err
);

    state_e            state_q, state_d;
    logic              msg_ready_q;
    logic [HDR_W-1:0]  hdr_q, hdr_d;
    logic [7:0]        idx_q, idx_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              overrun_q, overrun_d;

    logic              req_edge;
    logic              hdr_last;
    logic [BYTE_W-1:0] tx_data_c;
    logic              tx_valid_c;
    logic              tx_last_c;
    logic              pl_ready_c;

`ifdef AUTH_TX_CRC_EN
    logic              crc_clr;
    logic              crc_en;
    logic [7:0]        crc;

    auth_crc8 u_crc8 (
        .clk   (clk),
        .reset (reset),
        .clr   (crc_clr),
        .en    (crc_en),
        .din   (tx_data_c),
        .crc   (crc)
    );
`endif

    assign req_edge = MSG_ready & ~msg_ready_q;
    assign hdr_last = (idx_q == 8'(HDR_BYTES - 1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            msg_ready_q <= 1'b0;
            hdr_q       <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            msg_ready_q <= MSG_ready;
            hdr_q       <= hdr_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            overrun_q   <= overrun_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first; a path that
        // left one unassigned would infer a latch.
        state_d    = state_q;
        hdr_d      = hdr_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        overrun_d  = req_edge && (state_q != ST_IDLE);
        tx_data_c  = '0;
        tx_valid_c = 1'b0;
        tx_last_c  = 1'b0;
        pl_ready_c = 1'b0;
`ifdef AUTH_TX_CRC_EN
        crc_clr    = 1'b0;
        crc_en     = 1'b0;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (req_edge) begin
                    hdr_d   = header;
                    idx_d   = '0;
                    cnt_d   = sat_len(pl_len);
                    state_d = ST_HDR;
`ifdef AUTH_TX_CRC_EN
                    crc_clr = 1'b1;
`endif
                end
            end

            ST_HDR: begin
                // Header shifts left on each accepted byte, so the byte on
                // the link is always the top of the register and stays
                // stable while stalled.
                tx_valid_c = 1'b1;
                tx_data_c  = hdr_q[HDR_W-1 -: BYTE_W];
                tx_last_c  = hdr_last && (cnt_q == 8'd0) && !CRC_EN;
                if (link.tx_ready) begin
`ifdef AUTH_TX_CRC_EN
                    crc_en = 1'b1;
`endif
                    hdr_d = hdr_q << BYTE_W;
                    if (hdr_last) begin
                        state_d = (cnt_q == 8'd0) ? ST_TRAILER : ST_PL;
                    end else begin
                        idx_d = idx_q + 8'd1;
                    end
                end
            end

            ST_PL: begin
                // Straight pass-through; the source holds its byte while stalled.
                tx_valid_c = link.pl_valid;
                tx_data_c  = link.pl_data;
                tx_last_c  = link.pl_valid && (cnt_q == 8'd1) && !CRC_EN;
                pl_ready_c = link.tx_ready;
                if (link.pl_valid && link.tx_ready) begin
`ifdef AUTH_TX_CRC_EN
                    crc_en = 1'b1;
`endif
                    cnt_d = cnt_q - 8'd1;
                    if (cnt_q == 8'd1) begin
                        state_d = ST_TRAILER;
                    end
                end
            end

`ifdef AUTH_TX_CRC_EN
            ST_CRC: begin
                tx_valid_c = 1'b1;
                tx_data_c  = crc;
                tx_last_c  = 1'b1;
                if (link.tx_ready) begin
                    state_d = ST_DONE;
                end
            end
`endif

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign link.tx_data  = tx_data_c;
    assign link.tx_valid = tx_valid_c;
    assign link.tx_last  = tx_last_c;
    assign link.pl_ready = pl_ready_c;

    // DONE is not busy, so a request edge there is reported as an overrun
    // through the state_q != ST_IDLE term above, not through busy.
    assign busy        = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign msg_done    = (state_q == ST_DONE);
    assign overrun_err = overrun_q;

endmodule
